// File: rtl/mac_pkg.sv
// Shared types and width helpers for the windowed multiply/average datapath.
package mac_pkg;

  typedef enum logic {MODE_BLOCK, MODE_SLIDE} mac_mode_e;

  function automatic int unsigned acc_w(int unsigned width, int unsigned log2_win);
    return 2 * width + log2_win;
  endfunction

endpackage

// File: rtl/mac_window_avg_if.sv
// Sample-in / average-out valid-ready bus of mac_window_avg.
interface mac_window_avg_if #(
  parameter int unsigned WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     d1;
  logic [WIDTH-1:0]     d2;
  logic                 mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   average;

  modport master (
    output in_valid, d1, d2, mode, out_ready,
    input  in_ready, out_valid, average
  );

  modport slave (
    input  in_valid, d1, d2, mode, out_ready,
    output in_ready, out_valid, average
  );
endinterface

// File: rtl/mac_hist_buf.sv
// Ring buffer of the last WIN products for the sliding average; exposes the entry
// about to be overwritten (zero until the window has filled).
module mac_hist_buf #(
  parameter int unsigned DW       = 8,
  parameter int unsigned LOG2_WIN = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] evict,
  output logic          full_after
);
  localparam int unsigned WIN    = 1 << LOG2_WIN;
  localparam int unsigned PTR_W  = (LOG2_WIN == 0) ? 1 : LOG2_WIN;
  localparam int unsigned FILL_W = LOG2_WIN + 1;

  logic [DW-1:0]     mem [WIN];
  logic [PTR_W-1:0]  wptr_q, base_ptr, next_ptr;
  logic [FILL_W-1:0] fill_q, base_fill, next_fill;

  // A clear coinciding with a push makes that push sample 1 of a fresh window.
  assign base_ptr   = clear ? '0 : wptr_q;
  assign base_fill  = clear ? '0 : fill_q;
  assign next_ptr   = (base_ptr == PTR_W'(WIN - 1)) ? '0 : base_ptr + PTR_W'(1);
  assign next_fill  = (base_fill == FILL_W'(WIN)) ? base_fill : base_fill + FILL_W'(1);
  assign full_after = (base_fill >= FILL_W'(WIN - 1));
  assign evict      = (!clear && fill_q == FILL_W'(WIN)) ? mem[wptr_q] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      fill_q <= '0;
    end else if (push) begin
      wptr_q <= next_ptr;
      fill_q <= next_fill;
    end else if (clear) begin
      wptr_q <= '0;
      fill_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[base_ptr] <= wdata;
  end
endmodule

// File: rtl/mac_window_avg.sv
// Multiply two operands per sample and average products over a 2**LOG2_WIN window,
// block or sliding. Define MAC_ROUND_EN for round-half-up division instead of truncation.
module mac_window_avg
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOG2_WIN = 2
) (
  input logic              clk,
  input logic              reset,
  mac_window_avg_if.slave  bus
);
  localparam int unsigned WIN   = 1 << LOG2_WIN;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned ACC_W = acc_w(WIDTH, LOG2_WIN);
  localparam int unsigned CNT_W = (LOG2_WIN == 0) ? 1 : LOG2_WIN;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN - 1);
`ifdef MAC_ROUND_EN
  localparam logic [ACC_W-1:0] RND = (ACC_W'(1) << LOG2_WIN) >> 1;
`endif

  function automatic logic [PW-1:0] div(input logic [ACC_W-1:0] x);
    logic [ACC_W-1:0] t;
`ifdef MAC_ROUND_EN
    t = (x + RND) >> LOG2_WIN;
`else
    t = x >> LOG2_WIN;
`endif
    return t[PW-1:0];
  endfunction

  logic             en, step, restart, produce, full_after;
  logic [PW-1:0]    p_q, evict, average_q, average_d;
  logic             p_vld_q, out_valid_q, out_valid_d;
  mac_mode_e        p_mode_q, win_mode_q, win_mode_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum, div_in;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;

  assign en            = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.average   = average_q;
  assign step          = en && p_vld_q;
  assign restart       = (p_mode_q != win_mode_q);

  mac_hist_buf #(
    .DW       (PW),
    .LOG2_WIN (LOG2_WIN)
  ) u_hist (
    .clk        (clk),
    .reset      (reset),
    .clear      (step && restart),
    .push       (step && p_mode_q == MODE_SLIDE),
    .wdata      (p_q),
    .evict      (evict),
    .full_after (full_after)
  );

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    win_mode_d  = win_mode_q;
    average_d   = average_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    produce     = 1'b0;
    cnt_base    = restart ? '0 : cnt_q;
    sum         = (restart ? '0 : acc_q) + ACC_W'(p_q);
    div_in      = sum;
    if (step) begin
      win_mode_d = p_mode_q;
      if (p_mode_q == MODE_BLOCK) begin
        if (cnt_base == CNT_LAST) begin
          produce = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          acc_d = sum;
          cnt_d = cnt_base + CNT_W'(1);
        end
      end else begin
        acc_d   = sum - ACC_W'(evict);
        div_in  = acc_d;
        produce = full_after;
      end
      if (produce) begin
        out_valid_d = 1'b1;
        average_d   = div(div_in);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q         <= '0;
      p_vld_q     <= 1'b0;
      p_mode_q    <= MODE_BLOCK;
      win_mode_q  <= MODE_BLOCK;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      average_q   <= '0;
    end else begin
      if (en) begin
        p_vld_q <= bus.in_valid;
        if (bus.in_valid) begin
          p_q      <= PW'(bus.d1) * PW'(bus.d2);
          p_mode_q <= mac_mode_e'(bus.mode);
        end
      end
      win_mode_q  <= win_mode_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      average_q   <= average_d;
    end
  end
endmodule

// File: tb/tb_mac_window_avg.sv
// Bench for mac_window_avg: directed vector table, hand sequences, and random traffic
// against a queue-based window model.
module tb_mac_window_avg;
  localparam int WIDTH = 4;
  localparam int L     = 2;
  localparam int WIN   = 1 << L;
`ifdef MAC_ROUND_EN
  localparam int BLK_AVG = 63;
`else
  localparam int BLK_AVG = 62;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_window_avg_if #(.WIDTH(WIDTH)) bus ();

  mac_window_avg #(
    .WIDTH    (WIDTH),
    .LOG2_WIN (L)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;
  int out_cnt = 0;
  bit rand_bp = 1'b0;

  // Reference model: the products of the current window, and results still owed.
  int win_q[$];
  int exp_q[$];
  bit m_mode = 1'b0;
  int e;

  function automatic int mdiv(int s);
`ifdef MAC_ROUND_EN
    return (s + WIN / 2) / WIN;
`else
    return s / WIN;
`endif
  endfunction

  function automatic int qsum();
    int s = 0;
    foreach (win_q[i]) s += win_q[i];
    return s;
  endfunction

  task automatic model_accept(int p, bit md);
    if (md != m_mode) begin
      win_q.delete();
      m_mode = md;
    end
    win_q.push_back(p);
    if (!md) begin
      if (win_q.size() == WIN) begin
        exp_q.push_back(mdiv(qsum()));
        win_q.delete();
      end
    end else begin
      if (win_q.size() > WIN) void'(win_q.pop_front());
      if (win_q.size() == WIN) exp_q.push_back(mdiv(qsum()));
    end
  endtask

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else passes++;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      win_q.delete();
      exp_q.delete();
      m_mode = 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL sb_spurious: got average %0d, expected no output", bus.average);
        end else begin
          e = exp_q.pop_front();
          check("sb_avg", int'(bus.average), e);
        end
      end
      if (bus.in_valid && bus.in_ready)
        model_accept(int'(bus.d1) * int'(bus.d2), bus.mode);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(int a, int b, bit m);
    int n;
    n = 0;
    bus.d1       = WIDTH'(a);
    bus.d2       = WIDTH'(b);
    bus.mode     = m;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 500) begin
        checks++;
        $display("FAIL send_timeout: got in_ready 0 for %0d cycles, expected 1", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    bit rst;
    int d1;
    int d2;
    bit mode;
    bit exp_out;
    int exp_avg;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rst, int a, int b, bit m, bit eo, int ea);
    vec_t v;
    v.rst = rst; v.d1 = a; v.d2 = b; v.mode = m; v.exp_out = eo; v.exp_avg = ea;
    vecs.push_back(v);
  endfunction

  bit cur_mode;

  initial begin
    // Block window: products 15, 4, 7, 225.
    add(1, 3, 5, 0, 0, 0); add(0, 2, 2, 0, 0, 0); add(0, 1, 7, 0, 0, 0);
    add(0, 15, 15, 0, 1, BLK_AVG);
    // Sliding: products 4, 8, 12, 16, 20.
    add(1, 2, 2, 1, 0, 0); add(0, 2, 4, 1, 0, 0); add(0, 3, 4, 1, 0, 0);
    add(0, 4, 4, 1, 1, 10); add(0, 4, 5, 1, 1, 14);
    // Two block samples discarded by a switch to sliding.
    add(1, 1, 1, 0, 0, 0); add(0, 2, 3, 0, 0, 0);
    add(0, 2, 4, 1, 0, 0); add(0, 2, 4, 1, 0, 0); add(0, 2, 4, 1, 0, 0);
    add(0, 2, 4, 1, 1, 8);
    // Saturating products in both modes.
    for (int i = 0; i < 8; i++) add(i == 0, 15, 15, 0, (i % 4) == 3, 225);
    for (int i = 0; i < 8; i++) add(i == 0, 15, 15, 1, i >= 3, 225);

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.d1        = '0;
    bus.d2        = '0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_average", int'(bus.average), 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      send(vecs[i].d1, vecs[i].d2, vecs[i].mode);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), int'(bus.out_valid), int'(vecs[i].exp_out));
      if (vecs[i].exp_out)
        check($sformatf("vec%0d_avg", i), int'(bus.average), vecs[i].exp_avg);
    end

    // Backpressure: result pending with consumer stalled; one more sample queued behind it.
    do_reset();
    bus.out_ready = 1'b0;
    send(5, 5, 0); send(6, 6, 0); send(7, 7, 0); send(8, 8, 0);
    send(3, 3, 0);
    for (int c = 0; c < 4; c++) begin
      check("bp_in_ready", int'(bus.in_ready), 0);
      check("bp_out_valid", int'(bus.out_valid), 1);
      check("bp_average", int'(bus.average), (exp_q.size() > 0) ? exp_q[0] : -1);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(3, 2, 0); send(4, 4, 0); send(5, 5, 0);
    @(posedge clk);
    #1;
    check("bp_second_valid", int'(bus.out_valid), 1);
    check("bp_second_avg", int'(bus.average), (9 + 6 + 16 + 25) / WIN);

    // Reset mid-window after an earlier nonzero result.
    send(15, 15, 0); send(15, 15, 0); send(15, 15, 0); send(15, 15, 0);
    send(3, 3, 0); send(3, 3, 0); send(3, 3, 0);
    reset = 1'b1;
    #1;
    check("midrst_in_ready", int'(bus.in_ready), 1);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_average", int'(bus.average), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) send(1, 1, 0);
    @(posedge clk);
    #1;
    check("postrst_valid", int'(bus.out_valid), 1);
    check("postrst_avg", int'(bus.average), 1);

    // Random traffic with random backpressure.
    cur_mode = 1'b0;
    rand_bp  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) cur_mode = ~cur_mode;
      send($urandom_range(0, 15), $urandom_range(0, 15), cur_mode);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_bp       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("drain_pending", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
